mux4_rr_arbiter: RTL and testbench
==================================

Name: mux4_rr_arbiter

Overview:
Round-robin arbiter that shares one 4-to-1 single-bit mux path among four requesters. It owns the mux select lines (s1,s0), issues a one-hot grant, and forwards the granted requester's data bit to a single output. Each grant is bounded by a hold limit so that no requester can starve the others. It sits between four lab-level data sources and the shared 1-bit output line.

Parameters:
HOLD_MAX, 4, maximum consecutive cycles one grant may last; legal range 1..16.
CW, $clog2(HOLD_MAX+1) (localparam), hold counter width.

Ports:
clk  input  1  single system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
req  input  4  request lines; req[i] belongs to requester i.
d  input  4  data bits; d[i] is requester i's data.
sel  output  2  mux select {s1,s0}; registered.
gnt  output  4  one-hot grant; registered; 0000 when idle.
busy  output  1  high while in GRANT.
y  output  1  equals d[sel] when busy, otherwise 0; combinational from the registered sel.
hold_cnt  output  CW  cycles elapsed in the current grant; registered.

Behaviour:
- Reset, asynchronous, while rst_n=0: state=IDLE, sel=00, gnt=0000, busy=0, hold_cnt=0, ptr=0. y=0 follows combinationally. Reset asserted mid-grant clears everything immediately, with no clock edge required.
- ptr (2 bits, internal) is the highest-priority index. Search order is ptr, ptr+1, ptr+2, ptr+3, each mod 4.
- IDLE: if req==0, stay in IDLE. Otherwise, at the edge, take w = first asserted req in search order. Set sel=w, gnt=1<<w, busy=1, hold_cnt=0, and go to GRANT. Latency from req to gnt is 1 cycle.
- GRANT with owner o=sel. A release condition holds when req[o]==0 or hold_cnt==HOLD_MAX-1.
  - No release: hold_cnt increments; all other outputs hold.
  - Release: ptr becomes o+1 mod 4. Re-arbitrate in the same edge, using the new ptr, over the current req vector.
    - If any req is set: direct handoff to the winner, hold_cnt=0, and the state stays GRANT. There is no idle bubble.
    - If the owner is the only requester and the hold limit expired, the owner is re-granted (gnt unchanged, hold_cnt=0).
    - If req==0: go to IDLE, gnt=0000, busy=0, hold_cnt=0. sel keeps its last value.
- HOLD_MAX=1: every grant lasts exactly one cycle, giving a pure per-cycle round-robin.
- Requests arriving while another requester holds the grant are not latched. A requester must hold req high until granted.
- d is not registered. A change in d[o] appears on y in the same cycle.
- gnt is always one-hot or zero. busy == |gnt.
- sel changes only at a clock edge, so y is glitch-free with respect to select.

Decomposition:
- Shared package mux_arb_pkg:
  - state enum {IDLE, GRANT}
  - localparam NREQ=4
  - function onehot4(idx)
- Sub-module rr_pick4: combinational priority picker.
  - Inputs: req[3:0], ptr[1:0].
  - Outputs: any, idx[1:0].
  - It is used in both the IDLE and release paths.
- The top level holds the FSM, the counter, the ptr register and the output mux.

Test Plan:
- Reset and idle: rst_n=0 for 2 cycles, then req=0000 for 5 cycles -> sel=00, gnt=0000, busy=0, y=0, hold_cnt=0 throughout.
- Single requester, hold expiry: HOLD_MAX=4, req=0100 held, d=0100 -> gnt=0100 one cycle after req, sel=10, y=1. hold_cnt runs 0,1,2,3, then the grant is renewed with hold_cnt=0 and gnt staying 0100.
- Round-robin fairness: req=1111 held, HOLD_MAX=2 -> gnt sequence 0001,0001,0010,0010,0100,0100,1000,1000,0001 with no idle cycles. sel tracks 00,01,10,11.
- Early release and handoff: owner 1 holding (gnt=0010, hold_cnt=1), req changes 0010->1000 -> next edge gives gnt=1000, sel=11, hold_cnt=0. With d={1,x,0,1}, y=d3=1.
- Drop to idle: single owner 0 drops req, so req=0000 -> next edge gives gnt=0000, busy=0, y=0, sel stays 00. A later req=0001 is granted with ptr=1 search order, still winning index 0.
- Async reset mid-grant: gnt=0100, hold_cnt=2; drop rst_n between edges -> outputs clear immediately. After release, req=0100 is granted with ptr reset to 0.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the 4-way round-robin mux arbiter.
package mux_arb_pkg;

  localparam int unsigned NREQ = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic logic [NREQ-1:0] onehot4(input logic [1:0] idx);
    return NREQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational rotating-priority picker: first asserted req starting at ptr.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic       any,
  output logic [1:0] idx
);

  logic [1:0] k;

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    any = |req;
    idx = ptr;
    k   = ptr;
    for (int i = 3; i >= 0; i--) begin
      k = ptr + 2'(i);
      if (req[k]) idx = k;
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter owning a shared 4:1 single-bit mux; grants are bounded
// by HOLD_MAX cycles and hand off directly without an idle bubble.
module mux4_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter  int unsigned HOLD_MAX = 4,
  localparam int unsigned CW       = $clog2(HOLD_MAX + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      req,
  input  logic [3:0]      d,
  output logic [1:0]      sel,
  output logic [3:0]      gnt,
  output logic            busy,
  output logic            y,
  output logic [CW-1:0]   hold_cnt
);

  state_t          state, state_n;
  logic [1:0]      ptr, ptr_n, pick_ptr, win, sel_n;
  logic [3:0]      gnt_n;
  logic            busy_n, any, rel;
  logic [CW-1:0]   cnt_n;

  assign rel = !req[sel] || (hold_cnt == CW'(HOLD_MAX - 1));

  // On release the owner drops to lowest priority before re-arbitration.
  always_comb begin
    pick_ptr = ptr;
    if (state == GRANT && rel) pick_ptr = sel + 2'd1;
  end

  rr_pick4 u_pick (
    .req (req),
    .ptr (pick_ptr),
    .any (any),
    .idx (win)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= 2'd0;
      sel      <= 2'd0;
      gnt      <= 4'd0;
      busy     <= 1'b0;
      hold_cnt <= '0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      sel      <= sel_n;
      gnt      <= gnt_n;
      busy     <= busy_n;
      hold_cnt <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    sel_n   = sel;
    gnt_n   = gnt;
    busy_n  = busy;
    cnt_n   = hold_cnt;
    unique case (state)
      IDLE: begin
        if (any) begin
          state_n = GRANT;
          sel_n   = win;
          gnt_n   = onehot4(win);
          busy_n  = 1'b1;
          cnt_n   = '0;
        end
      end
      GRANT: begin
        if (!rel) begin
          cnt_n = hold_cnt + CW'(1);
        end else begin
          ptr_n = pick_ptr;
          cnt_n = '0;
          if (any) begin
            sel_n  = win;
            gnt_n  = onehot4(win);
            busy_n = 1'b1;
          end else begin
            state_n = IDLE;
            gnt_n   = 4'd0;
            busy_n  = 1'b0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // sel is registered, so y only moves with d or at a clock edge.
  assign y = busy & d[sel];

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter at HOLD_MAX = 4, 2 and 1.
module tb_mux4_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'd0;
  logic [3:0] d = 4'd0;

  logic [1:0] sel4, sel2, sel1;
  logic [3:0] gnt4, gnt2, gnt1;
  logic       busy4, busy2, busy1, y4, y2, y1;
  logic [2:0] hc4;
  logic [1:0] hc2;
  logic [0:0] hc1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux4_rr_arbiter #(.HOLD_MAX(4)) u4 (
    .clk(clk), .rst_n(rst_n), .req(req), .d(d),
    .sel(sel4), .gnt(gnt4), .busy(busy4), .y(y4), .hold_cnt(hc4)
  );
  mux4_rr_arbiter #(.HOLD_MAX(2)) u2 (
    .clk(clk), .rst_n(rst_n), .req(req), .d(d),
    .sel(sel2), .gnt(gnt2), .busy(busy2), .y(y2), .hold_cnt(hc2)
  );
  mux4_rr_arbiter #(.HOLD_MAX(1)) u1 (
    .clk(clk), .rst_n(rst_n), .req(req), .d(d),
    .sel(sel1), .gnt(gnt1), .busy(busy1), .y(y1), .hold_cnt(hc1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic chk4(input string tag, input logic [1:0] s, input logic [3:0] g,
                      input logic b, input logic yy, input logic [2:0] h);
    chk({tag, ".sel"},  32'(sel4),  32'(s));
    chk({tag, ".gnt"},  32'(gnt4),  32'(g));
    chk({tag, ".busy"}, 32'(busy4), 32'(b));
    chk({tag, ".y"},    32'(y4),    32'(yy));
    chk({tag, ".hold"}, 32'(hc4),   32'(h));
  endtask

  initial begin
    logic [3:0] g2_exp [9];
    logic [1:0] s2_exp [9];
    g2_exp = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001};
    s2_exp = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};

    // Reset held for two cycles, then idle with no requests.
    #1;
    tick();
    chk4("rst0", 2'd0, 4'b0000, 1'b0, 1'b0, 3'd0);
    tick();
    chk4("rst1", 2'd0, 4'b0000, 1'b0, 1'b0, 3'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk4("idle", 2'd0, 4'b0000, 1'b0, 1'b0, 3'd0);
    end

    // Single requester 2 with hold expiry and self re-grant (HOLD_MAX=4).
    do_reset();
    req = 4'b0100;
    d   = 4'b0100;
    chk("single.pre_gnt", 32'(gnt4), 32'(4'b0000));
    tick();
    chk4("single.h0", 2'd2, 4'b0100, 1'b1, 1'b1, 3'd0);
    tick();
    chk4("single.h1", 2'd2, 4'b0100, 1'b1, 1'b1, 3'd1);
    tick();
    chk4("single.h2", 2'd2, 4'b0100, 1'b1, 1'b1, 3'd2);
    tick();
    chk4("single.h3", 2'd2, 4'b0100, 1'b1, 1'b1, 3'd3);
    tick();
    chk4("single.renew", 2'd2, 4'b0100, 1'b1, 1'b1, 3'd0);
    d = 4'b0000;
    #1;
    chk("single.y_follows_d", 32'(y4), 32'(1'b0));

    // All requesting: HOLD_MAX=2 pairs, HOLD_MAX=1 pure per-cycle rotation.
    do_reset();
    req = 4'b1111;
    d   = 4'b1010;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk($sformatf("rr2.gnt[%0d]", i), 32'(gnt2), 32'(g2_exp[i]));
      chk($sformatf("rr2.sel[%0d]", i), 32'(sel2), 32'(s2_exp[i]));
      chk($sformatf("rr2.busy[%0d]", i), 32'(busy2), 32'(1'b1));
      chk($sformatf("rr1.gnt[%0d]", i), 32'(gnt1), 32'(4'b0001 << (i % 4)));
      chk($sformatf("rr1.hold[%0d]", i), 32'(hc1), 32'(1'b0));
      chk($sformatf("rr1.y[%0d]", i), 32'(y1), 32'((i % 2) == 1));
    end

    // Early release with direct handoff from owner 1 to requester 3.
    do_reset();
    req = 4'b0010;
    d   = 4'b1x01;
    tick();
    chk4("early.h0", 2'd1, 4'b0010, 1'b1, 1'b0, 3'd0);
    tick();
    chk4("early.h1", 2'd1, 4'b0010, 1'b1, 1'b0, 3'd1);
    req = 4'b1000;
    tick();
    chk4("early.handoff", 2'd3, 4'b1000, 1'b1, 1'b1, 3'd0);

    // Drop to idle keeps sel; ptr moved past owner 0.
    do_reset();
    req = 4'b0001;
    d   = 4'b0001;
    tick();
    chk4("drop.gnt0", 2'd0, 4'b0001, 1'b1, 1'b1, 3'd0);
    req = 4'b0000;
    tick();
    chk4("drop.idle", 2'd0, 4'b0000, 1'b0, 1'b0, 3'd0);
    req = 4'b0001;
    tick();
    chk4("drop.regrant0", 2'd0, 4'b0001, 1'b1, 1'b1, 3'd0);
    req = 4'b0000;
    tick();
    chk4("drop.idle2", 2'd0, 4'b0000, 1'b0, 1'b0, 3'd0);
    req = 4'b0011;
    tick();
    chk4("drop.ptr1_pick", 2'd1, 4'b0010, 1'b1, 1'b0, 3'd0);

    // Async reset mid-grant clears outputs without an edge and resets ptr.
    do_reset();
    req = 4'b0001;
    d   = 4'b0100;
    tick();
    chk("arst.gnt0", 32'(gnt4), 32'(4'b0001));
    req = 4'b0100;
    tick();
    chk4("arst.h0", 2'd2, 4'b0100, 1'b1, 1'b1, 3'd0);
    tick();
    tick();
    chk4("arst.h2", 2'd2, 4'b0100, 1'b1, 1'b1, 3'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk4("arst.cleared", 2'd0, 4'b0000, 1'b0, 1'b0, 3'd0);
    req = 4'b0101;
    tick();
    rst_n = 1'b1;
    tick();
    chk4("arst.ptr0_pick", 2'd0, 4'b0001, 1'b1, 1'b0, 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
